// File: rtl/local_mem_port_ctrl_if.sv
// Core-side request/response bundle for the local-memory port controller.
// The core drives requests as master; the controller serves them as slave.
interface local_mem_port_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_sign, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_sign, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/local_mem_port_ctrl.sv
// Request-side controller for one byte-enable local-memory RAM port: address/BE/data
// generation, read-data alignment and extension, and an in-order response FIFO.
module local_mem_port_ctrl #(
  parameter int LINES      = 4096,
  parameter int RESP_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  local_mem_port_ctrl_if.slave     core,
  output logic [$clog2(LINES)-1:0] ram_addr,
  output logic                     ram_en,
  output logic [3:0]               ram_be,
  output logic [31:0]              ram_data_in,
  input  logic [31:0]              ram_data_out
);

  localparam int AW = $clog2(LINES);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef logic [32:0] entry_t;  // {err, rdata}

  logic          accept;
  logic          req_err;
  logic          pop;
  logic          push;
  logic          rsp_valid_w;
  logic [3:0]    store_be;
  logic [31:0]   shifted;
  logic [31:0]   aligned;
  logic          unused_addr_bits;

  logic          ready_q, ready_d;
  logic [CW-1:0] outstanding_q, outstanding_d;

  logic          if_valid_q, if_valid_d;
  logic [1:0]    if_off_q, if_off_d;
  logic [1:0]    if_size_q, if_size_d;
  logic          if_sign_q, if_sign_d;
  logic          if_we_q, if_we_d;
  logic          if_err_q, if_err_d;

  entry_t        fifo_q [RESP_DEPTH];
  entry_t        fifo_d [RESP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Upper address bits are deliberately dropped: the RAM aliases modulo LINES*4.
  assign unused_addr_bits = ^core.req_addr[31:AW+2];

  // ready is a pure flop so the core never sees a path from req_valid or rsp_ready.
  assign core.req_ready = ready_q;
  assign accept         = core.req_valid && ready_q;

  always_comb begin
    req_err = 1'b0;
    case (core.req_size)
      SZ_HALF: req_err = core.req_addr[0];
      SZ_WORD: req_err = (core.req_addr[1:0] != 2'b00);
      SZ_BAD:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  assign ram_en   = accept && !req_err;
  assign ram_addr = core.req_addr[AW+1:2];
  assign ram_be   = core.req_we ? store_be : 4'b0000;

  // Per byte lane: enable and replicated write data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_be[gi] =
          (core.req_size == SZ_BYTE) ? (core.req_addr[1:0] == 2'(gi)) :
          (core.req_size == SZ_HALF) ? (core.req_addr[1] == 1'(gi / 2)) :
                                       1'b1;
      assign ram_data_in[8*gi +: 8] =
          (core.req_size == SZ_BYTE) ? core.req_wdata[7:0] :
          (core.req_size == SZ_HALF) ? core.req_wdata[8*(gi % 2) +: 8] :
                                       core.req_wdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    if_valid_d = accept;
    if_off_d   = if_off_q;
    if_size_d  = if_size_q;
    if_sign_d  = if_sign_q;
    if_we_d    = if_we_q;
    if_err_d   = if_err_q;
    if (accept) begin
      if_off_d  = core.req_addr[1:0];
      if_size_d = core.req_size;
      if_sign_d = core.req_sign;
      if_we_d   = core.req_we;
      if_err_d  = req_err;
    end
  end

  // Read data arrives the cycle after accept; align and extend it from the in-flight stage.
  always_comb begin
    shifted = ram_data_out >> {if_off_q, 3'b000};
    aligned = shifted;
    case (if_size_q)
      SZ_BYTE: aligned = {{24{if_sign_q & shifted[7]}}, shifted[7:0]};
      SZ_HALF: aligned = {{16{if_sign_q & shifted[15]}}, shifted[15:0]};
      default: aligned = shifted;
    endcase
    if (if_we_q || if_err_q) begin
      aligned = 32'h0;
    end
  end

  assign push        = if_valid_q;
  assign rsp_valid_w = (count_q != '0);
  assign pop         = rsp_valid_w && core.rsp_ready;

  assign core.rsp_valid = rsp_valid_w;
  assign core.rsp_rdata = fifo_q[rd_ptr_q][31:0];
  assign core.rsp_err   = fifo_q[rd_ptr_q][32];

  // Outstanding covers in-flight plus queued entries, so a push never finds the FIFO full
  // unless a pop happens in the same cycle.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {if_err_q, aligned};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    ready_d = (outstanding_d < CW'(RESP_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q       <= 1'b0;
      outstanding_q <= '0;
      if_valid_q    <= 1'b0;
      if_off_q      <= 2'b00;
      if_size_q     <= 2'b00;
      if_sign_q     <= 1'b0;
      if_we_q       <= 1'b0;
      if_err_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      ready_q       <= ready_d;
      outstanding_q <= outstanding_d;
      if_valid_q    <= if_valid_d;
      if_off_q      <= if_off_d;
      if_size_q     <= if_size_d;
      if_sign_q     <= if_sign_d;
      if_we_q       <= if_we_d;
      if_err_q      <= if_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fifo_q        <= fifo_d;
    end
  end

endmodule

// File: tb/tb_local_mem_port_ctrl.sv
// Scoreboard bench for local_mem_port_ctrl: directed requests push expected responses,
// a monitor pops and compares whenever the DUT presents a response.
module tb_local_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] ram_addr;
  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out = 32'h0;
  logic [31:0] line_drv = 32'h0;

  local_mem_port_ctrl_if bus ();

  local_mem_port_ctrl #(.LINES(4096), .RESP_DEPTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .core         (bus),
    .ram_addr     (ram_addr),
    .ram_en       (ram_en),
    .ram_be       (ram_be),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM stand-in: the line chosen with the request appears one cycle after the accept edge.
  always @(posedge clk) ram_data_out <= line_drv;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_rsp    = 0;
  int          wait_total = 0;
  logic [32:0] exp_q[$];
  int          acc_q[$];
  int          rsp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: samples just after the falling edge so stimulus driven on that edge has settled.
  always @(negedge clk) begin
    logic [32:0] e;
    int          a;
    #1;
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(bus.rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else if (bus.rsp_ready) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e[31:0]));
        check("rsp_err", 64'(bus.rsp_err), 64'(e[32]));
        check("rsp_latency_ge2", 64'(cyc - a >= 2), 64'd1);
        rsp_cyc_q.push_back(cyc);
        n_rsp++;
        $display("rsp %0d: cycle=%0d rdata=%08h err=%0b (expected %08h/%0b)",
                 n_rsp, cyc, bus.rsp_rdata, bus.rsp_err, e[31:0], e[32]);
      end else begin
        e = exp_q[0];
        check("hold_rdata", 64'(bus.rsp_rdata), 64'(e[31:0]));
        check("hold_err", 64'(bus.rsp_err), 64'(e[32]));
      end
    end
  end

  // Issue one request at a falling edge; returns at the falling edge after it is accepted.
  task automatic send(input logic [31:0] addr, input logic we, input logic [1:0] size,
                      input logic sign, input logic [31:0] wdata, input logic [31:0] line,
                      input logic exp_err, input logic [31:0] exp_rdata,
                      input logic [11:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_din);
    int w = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sign  = sign;
    bus.req_wdata = wdata;
    line_drv      = line;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    wait_total += w;
    #1;
    if (!bus.req_ready) begin
      check("req_accept_timeout", 64'(bus.req_ready), 64'd1);
    end else begin
      check("ram_en", 64'(ram_en), 64'(!exp_err));
      if (!exp_err) begin
        check("ram_addr", 64'(ram_addr), 64'(exp_addr));
        check("ram_be", 64'(ram_be), 64'(exp_be));
        if (we) check("ram_data_in", 64'(ram_data_in), 64'(exp_din));
      end
      exp_q.push_back({exp_err, exp_rdata});
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Three word loads with rsp_ready low, then show a fourth request is refused.
  task automatic fill_and_block(input logic [31:0] base);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(base + 32'(4 * i), 1'b0, 2'b10, 1'b0, 32'h0, 32'hA000_0000 + base + 32'(i),
           1'b0, 32'hA000_0000 + base + 32'(i), 12'((base >> 2) + 32'(i)), 4'h0, 32'h0);
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = base + 32'h40;
    bus.req_size  = 2'b10;
    bus.req_we    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("blocked_req_ready", 64'(bus.req_ready), 64'd0);
      check("blocked_ram_en", 64'(ram_en), 64'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_sign  = 1'b0;
    bus.req_wdata = 32'h1234_5678;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_ram_en", 64'(ram_en), 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("post_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);

    // Directed stores and loads
    send(32'h10,   1, 2'b10, 0, 32'hDEADBEEF, 32'h0,         0, 32'h0,        12'h004, 4'hF, 32'hDEADBEEF);
    send(32'h13,   1, 2'b00, 0, 32'h000000A5, 32'h0,         0, 32'h0,        12'h004, 4'h8, 32'hA5A5A5A5);
    send(32'h13,   0, 2'b00, 1, 32'h0,        32'hA5000000,  0, 32'hFFFFFFA5, 12'h004, 4'h0, 32'h0);
    send(32'h13,   0, 2'b00, 0, 32'h0,        32'hA5000000,  0, 32'h000000A5, 12'h004, 4'h0, 32'h0);
    send(32'h22,   0, 2'b01, 1, 32'h0,        32'h80017FFF,  0, 32'hFFFF8001, 12'h008, 4'h0, 32'h0);
    send(32'h22,   0, 2'b01, 0, 32'h0,        32'h80017FFF,  0, 32'h00008001, 12'h008, 4'h0, 32'h0);
    send(32'h22,   1, 2'b01, 0, 32'h00001234, 32'h0,         0, 32'h0,        12'h008, 4'hC, 32'h12341234);
    send(32'h01,   1, 2'b00, 0, 32'h0000003C, 32'h0,         0, 32'h0,        12'h000, 4'h2, 32'h3C3C3C3C);
    send(32'h4004, 0, 2'b10, 0, 32'h0,        32'hCAFEF00D,  0, 32'hCAFEF00D, 12'h001, 4'h0, 32'h0);
    send(32'h00,   0, 2'b00, 1, 32'h0,        32'h12345680,  0, 32'hFFFFFF80, 12'h000, 4'h0, 32'h0);
    send(32'h06,   0, 2'b10, 0, 32'h0,        32'h11111111,  1, 32'h0,        12'h000, 4'h0, 32'h0);
    send(32'h00,   0, 2'b11, 1, 32'h0,        32'h22222222,  1, 32'h0,        12'h000, 4'h0, 32'h0);
    send(32'h05,   1, 2'b01, 0, 32'h0000BEEF, 32'h0,         1, 32'h0,        12'h000, 4'h0, 32'h0);
    wait_drain("drain_directed");

    // Back-to-back word loads at full rate
    wait_total = 0;
    rsp_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(32'h100 + 32'(4 * i), 0, 2'b10, 0, 32'h0, 32'h1000_0000 + 32'(i),
           0, 32'h1000_0000 + 32'(i), 12'h040 + 12'(i), 4'h0, 32'h0);
    end
    wait_drain("drain_b2b");
    check("b2b_no_stall", 64'(wait_total), 64'd0);
    check("b2b_rsp_count", 64'(rsp_cyc_q.size()), 64'd8);
    if (rsp_cyc_q.size() == 8) check("b2b_rsp_span", 64'(rsp_cyc_q[7] - rsp_cyc_q[0]), 64'd7);

    // Backpressure: three accepted, rest refused, then full drain
    fill_and_block(32'h200);
    check("bp_queued", 64'(exp_q.size()), 64'd3);
    bus.rsp_ready = 1'b1;
    wait_drain("drain_bp");
    #1;
    check("bp_ready_after_drain", 64'(bus.req_ready), 64'd1);
    check("bp_valid_after_drain", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);

    // Reset in the middle of a drain
    fill_and_block(32'h300);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    check("midrst_ram_en", 64'(ram_en), 64'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("after_rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("after_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);

    // Exactly three more fit, proving the outstanding count restarted at zero
    fill_and_block(32'h400);
    bus.rsp_ready = 1'b1;
    wait_drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
